// File: rtl/fibonacci_index_pkg.sv
// Shared definitions for the Fibonacci inverse search: FSM encodings and
// a short table of the first sequence values, F(1)..F(12).
package fibonacci_index_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int FIB_TABLE_LEN = 12;

  localparam logic [31:0] FIB_TABLE [1:FIB_TABLE_LEN] = '{
    32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
    32'd13, 32'd21, 32'd34, 32'd55, 32'd89, 32'd144
  };

endpackage

// File: rtl/fibonacci_index.sv
// Inverse Fibonacci search: walks F(1), F(2), ... until F(k) >= x, and
// reports k together with an exact-match flag and an overflow flag.
// The start input doubles as an asynchronous active-low clear.
module fibonacci_index
  import fibonacci_index_pkg::*;
#(
  parameter int in_size  = 32,
  parameter int out_size = 32
) (
  input  logic                clk,
  input  logic                start,
  input  logic [out_size-1:0] x,
  output logic                valid,
  output logic [in_size-1:0]  idx,
  output logic                found,
  output logic                overflow
);

  state_t              state;
  logic [out_size-1:0] x_q;
  logic [out_size-1:0] a;
  logic [out_size-1:0] b;
  logic [in_size-1:0]  k;
  logic [out_size:0]   sum;
  logic                k_max;

  // Next sequence term with one extra bit so the carry shows that it no longer fits
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    k_max = &k;
  end

  // Search FSM: capture x, step (a, b) = (F(k-1), F(k)) until a result is known, then hold
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state    <= LOAD;
      valid    <= 1'b0;
      idx      <= '0;
      found    <= 1'b0;
      overflow <= 1'b0;
      x_q      <= '0;
      a        <= '0;
      b        <= {{(out_size-1){1'b0}}, 1'b1};
      k        <= {{(in_size-1){1'b0}}, 1'b1};
    end else begin
      case (state)
        LOAD: begin
          x_q   <= x;
          state <= SEARCH;
        end
        SEARCH: begin
          if (b >= x_q) begin
            idx      <= k;
            found    <= (b == x_q);
            overflow <= 1'b0;
            valid    <= 1'b1;
            state    <= DONE;
          end else if (sum[out_size]) begin
            idx      <= k + 1'b1;
            found    <= 1'b0;
            overflow <= 1'b1;
            valid    <= 1'b1;
            state    <= DONE;
          end else if (k_max) begin
            idx      <= k;
            found    <= 1'b0;
            overflow <= 1'b1;
            valid    <= 1'b1;
            state    <= DONE;
          end else begin
            a <= b;
            b <= sum[out_size-1:0];
            k <= k + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
